// File: rtl/apb2axi_pkg.sv
// Shared types and widths for the APB-to-AXI bridge: directory entry layout,
// AXI field widths and AXI burst encodings.
package apb2axi_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_ID_W   = 4;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef struct packed {
    logic                  is_write;
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } directory_entry_t;

  localparam int REQ_WIDTH = $bits(directory_entry_t);

endpackage

// File: rtl/apb2axi_credit_cnt.sv
// Up/down in-flight counter that saturates at MAX_CNT and flags a decrement
// seen while empty. Shared by the read issuer (R last beats) and write issuer.
module apb2axi_credit_cnt import apb2axi_pkg::*; #(
  parameter int MAX_CNT = 4,
  parameter int CNT_W   = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_underflow
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_underflow;
  logic             w_empty;
  logic             w_full;
  logic             w_dec_eff;

  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == CNT_W'(MAX_CNT));
  // A completion with nothing in flight is bogus: flag it and leave the count alone.
  assign w_dec_eff = i_dec && !w_empty;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt       <= '0;
      r_underflow <= 1'b0;
    end else begin
      if (i_dec && w_empty) begin
        r_underflow <= 1'b1;
      end
      case ({i_inc, w_dec_eff})
        2'b10:   if (!w_full) r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_cnt       = r_cnt;
  assign o_underflow = r_underflow;

endmodule

// File: rtl/apb2axi_rd_issuer.sv
// Pops committed read entries from the RD request FIFO and issues them on the
// AXI AR channel, throttled by an outstanding-read credit counter.
module apb2axi_rd_issuer import apb2axi_pkg::*; #(
  parameter int FIFO_ENTRY_W    = REQ_WIDTH,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    fifo_pop_valid,
  output logic                    fifo_pop_ready,
  input  logic [FIFO_ENTRY_W-1:0] fifo_pop_data,
  output logic                    arvalid,
  input  logic                    arready,
  output logic [AXI_ADDR_W-1:0]   araddr,
  output logic [AXI_ID_W-1:0]     arid,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  input  logic                    rvalid,
  input  logic                    rready,
  input  logic                    rlast,
  output logic [3:0]              outstanding,
  output logic                    busy,
  output logic                    err_bad_entry,
  output logic                    err_underflow
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  logic [0:0]            r_state;
  logic [0:0]            w_state_nxt;
  logic [AXI_ADDR_W-1:0] r_araddr;
  logic [AXI_ID_W-1:0]   r_arid;
  logic [7:0]            r_arlen;
  logic [2:0]            r_arsize;
  logic [1:0]            r_arburst;
  logic                  r_err_bad;

  directory_entry_t      w_entry;
  logic                  w_ar_hs;
  logic                  w_r_done;
  logic                  w_credit_ok;
  logic                  w_pop;
  logic                  w_pop_good;
  logic                  w_pop_bad;
  logic [3:0]            w_outstanding;
  logic                  w_underflow;

  assign w_entry  = directory_entry_t'(fifo_pop_data);
  assign w_ar_hs  = arvalid && arready;
  assign w_r_done = rvalid && rready && rlast;

  // Credits freed by R completions this cycle are not counted until next cycle.
  assign w_credit_ok    = ({1'b0, w_outstanding} + {4'd0, w_ar_hs}) < 5'(MAX_OUTSTANDING);
  assign fifo_pop_ready = aresetn && fifo_pop_valid
                          && (r_state == ST_IDLE || w_ar_hs) && w_credit_ok;

  assign w_pop      = fifo_pop_ready;
  assign w_pop_good = w_pop && !w_entry.is_write;
  assign w_pop_bad  = w_pop && w_entry.is_write;

  always_comb begin
    w_state_nxt = r_state;
    if (w_pop_good) begin
      w_state_nxt = ST_ISSUE;
    end else if (w_pop || w_ar_hs) begin
      w_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state   <= ST_IDLE;
      r_araddr  <= '0;
      r_arid    <= '0;
      r_arlen   <= '0;
      r_arsize  <= '0;
      r_arburst <= '0;
      r_err_bad <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop_good) begin
        r_araddr  <= w_entry.addr;
        r_arid    <= w_entry.id;
        r_arlen   <= w_entry.len;
        r_arsize  <= w_entry.size;
        r_arburst <= w_entry.burst;
      end
      if (w_pop_bad) begin
        r_err_bad <= 1'b1;
      end
    end
  end

  apb2axi_credit_cnt #(
    .MAX_CNT (MAX_OUTSTANDING),
    .CNT_W   (4)
  ) u_credit (
    .i_clk       (aclk),
    .i_rst_n     (aresetn),
    .i_inc       (w_ar_hs),
    .i_dec       (w_r_done),
    .o_cnt       (w_outstanding),
    .o_underflow (w_underflow)
  );

  assign arvalid       = (r_state == ST_ISSUE);
  assign araddr        = r_araddr;
  assign arid          = r_arid;
  assign arlen         = r_arlen;
  assign arsize        = r_arsize;
  assign arburst       = r_arburst;
  assign outstanding   = w_outstanding;
  assign busy          = arvalid || (w_outstanding != 4'd0);
  assign err_bad_entry = r_err_bad;
  assign err_underflow = w_underflow;

endmodule

// File: tb/tb_apb2axi_rd_issuer.sv
// Directed bench for apb2axi_rd_issuer: FIFO models feed two instances
// (4 and 2 credits); AR handshakes are scored against queued expectations.
module tb_apb2axi_rd_issuer;
  import apb2axi_pkg::*;

  localparam int PW = AXI_ADDR_W + AXI_ID_W + 8 + 3 + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic aresetn;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: MAX_OUTSTANDING = 4
  logic                  pv_a, pr_a, arvalid_a, arready_a, rvalid_a, rready_a, rlast_a;
  logic [REQ_WIDTH-1:0]  pd_a;
  logic [AXI_ADDR_W-1:0] araddr_a;
  logic [AXI_ID_W-1:0]   arid_a;
  logic [7:0]            arlen_a;
  logic [2:0]            arsize_a;
  logic [1:0]            arburst_a;
  logic [3:0]            outst_a;
  logic                  busy_a, ebad_a, eund_a;

  // Instance B: MAX_OUTSTANDING = 2
  logic                  pv_b, pr_b, arvalid_b, arready_b, rvalid_b, rready_b, rlast_b;
  logic [REQ_WIDTH-1:0]  pd_b;
  logic [AXI_ADDR_W-1:0] araddr_b;
  logic [AXI_ID_W-1:0]   arid_b;
  logic [7:0]            arlen_b;
  logic [2:0]            arsize_b;
  logic [1:0]            arburst_b;
  logic [3:0]            outst_b;
  logic                  busy_b, ebad_b, eund_b;

  apb2axi_rd_issuer #(.FIFO_ENTRY_W(REQ_WIDTH), .MAX_OUTSTANDING(4)) dut_a (
    .aclk(clk), .aresetn(aresetn),
    .fifo_pop_valid(pv_a), .fifo_pop_ready(pr_a), .fifo_pop_data(pd_a),
    .arvalid(arvalid_a), .arready(arready_a), .araddr(araddr_a), .arid(arid_a),
    .arlen(arlen_a), .arsize(arsize_a), .arburst(arburst_a),
    .rvalid(rvalid_a), .rready(rready_a), .rlast(rlast_a),
    .outstanding(outst_a), .busy(busy_a), .err_bad_entry(ebad_a), .err_underflow(eund_a)
  );

  apb2axi_rd_issuer #(.FIFO_ENTRY_W(REQ_WIDTH), .MAX_OUTSTANDING(2)) dut_b (
    .aclk(clk), .aresetn(aresetn),
    .fifo_pop_valid(pv_b), .fifo_pop_ready(pr_b), .fifo_pop_data(pd_b),
    .arvalid(arvalid_b), .arready(arready_b), .araddr(araddr_b), .arid(arid_b),
    .arlen(arlen_b), .arsize(arsize_b), .arburst(arburst_b),
    .rvalid(rvalid_b), .rready(rready_b), .rlast(rlast_b),
    .outstanding(outst_b), .busy(busy_b), .err_bad_entry(ebad_b), .err_underflow(eund_b)
  );

  // First-word-fall-through FIFO models: tail written by stimulus, head by pops.
  logic [REQ_WIDTH-1:0] fm_a [16];
  logic [REQ_WIDTH-1:0] fm_b [16];
  int fh_a = 0, ft_a = 0, fh_b = 0, ft_b = 0;

  assign pv_a = (fh_a != ft_a);
  assign pd_a = fm_a[fh_a[3:0]];
  assign pv_b = (fh_b != ft_b);
  assign pd_b = fm_b[fh_b[3:0]];

  always @(posedge clk) if (pv_a && pr_a) fh_a <= fh_a + 1;
  always @(posedge clk) if (pv_b && pr_b) fh_b <= fh_b + 1;

  // AR handshake capture: payload and the cycle count just before the accepting edge.
  logic [PW-1:0] hp_a [32];
  logic [PW-1:0] hp_b [32];
  int hc_a [32];
  int hc_b [32];
  int hn_a = 0, hn_b = 0;

  always @(negedge clk) begin
    if (arvalid_a && arready_a) begin
      hp_a[hn_a[4:0]] <= {araddr_a, arid_a, arlen_a, arsize_a, arburst_a};
      hc_a[hn_a[4:0]] <= cyc;
      hn_a            <= hn_a + 1;
    end
  end

  always @(negedge clk) begin
    if (arvalid_b && arready_b) begin
      hp_b[hn_b[4:0]] <= {araddr_b, arid_b, arlen_b, arsize_b, arburst_b};
      hc_b[hn_b[4:0]] <= cyc;
      hn_b            <= hn_b + 1;
    end
  end

  logic [PW-1:0] exp_a [$];
  logic [PW-1:0] exp_b [$];
  int sr_a = 0, sr_b = 0;
  int rdc;

  function automatic directory_entry_t mk(input logic w, input logic [31:0] a,
      input logic [3:0] id, input logic [7:0] len, input logic [2:0] sz, input logic [1:0] bu);
    directory_entry_t e;
    e.is_write = w;
    e.addr     = a;
    e.id       = id;
    e.len      = len;
    e.size     = sz;
    e.burst    = bu;
    return e;
  endfunction

  function automatic logic [PW-1:0] pay(input directory_entry_t e);
    return {e.addr, e.id, e.len, e.size, e.burst};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_a(input directory_entry_t e, input bit expect_ar);
    fm_a[ft_a[3:0]] = e;
    ft_a++;
    if (expect_ar) exp_a.push_back(pay(e));
  endtask

  task automatic push_b(input directory_entry_t e, input bit expect_ar);
    fm_b[ft_b[3:0]] = e;
    ft_b++;
    if (expect_ar) exp_b.push_back(pay(e));
  endtask

  task automatic score_a();
    while (sr_a < hn_a) begin
      total++;
      assert (exp_a.size() != 0) else begin
        bad++;
        $error("FAIL a_ar_extra observed=%0h expected=none", hp_a[sr_a[4:0]]);
      end
      if (exp_a.size() != 0) chk("a_ar_payload", 64'(hp_a[sr_a[4:0]]), 64'(exp_a.pop_front()));
      sr_a++;
    end
  endtask

  task automatic score_b();
    while (sr_b < hn_b) begin
      total++;
      assert (exp_b.size() != 0) else begin
        bad++;
        $error("FAIL b_ar_extra observed=%0h expected=none", hp_b[sr_b[4:0]]);
      end
      if (exp_b.size() != 0) chk("b_ar_payload", 64'(hp_b[sr_b[4:0]]), 64'(exp_b.pop_front()));
      sr_b++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    aresetn   = 1'b0;
    arready_a = 1'b0; rvalid_a = 1'b0; rready_a = 1'b1; rlast_a = 1'b0;
    arready_b = 1'b0; rvalid_b = 1'b0; rready_b = 1'b1; rlast_b = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_arvalid", 64'(arvalid_a), 64'd0);
    chk("rst_outstanding", 64'(outst_a), 64'd0);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_err_bad", 64'(ebad_a), 64'd0);
    chk("rst_err_underflow", 64'(eund_a), 64'd0);
    chk("rst_ar_payload", 64'({araddr_a, arid_a, arlen_a, arsize_a, arburst_a}), 64'd0);

    // Single read; entry already at the FIFO head while reset is held
    arready_a = 1'b1;
    push_a(mk(1'b0, 32'h1000, 4'd3, 8'd7, 3'd2, BURST_INCR), 1'b1);
    tick();
    chk("rst_pop_gated", 64'(pr_a), 64'd0);
    aresetn = 1'b1;
    tick();
    chk("t1_arvalid", 64'(arvalid_a), 64'd1);
    chk("t1_outst_before_hs", 64'(outst_a), 64'd0);
    tick();
    chk("t1_arvalid_one_cycle", 64'(arvalid_a), 64'd0);
    chk("t1_hs_count", 64'(hn_a), 64'd1);
    chk("t1_outst", 64'(outst_a), 64'd1);
    chk("t1_busy", 64'(busy_a), 64'd1);
    score_a();
    rvalid_a = 1'b1; rlast_a = 1'b1;
    tick();
    rvalid_a = 1'b0; rlast_a = 1'b0;
    chk("t1_outst_done", 64'(outst_a), 64'd0);
    chk("t1_busy_done", 64'(busy_a), 64'd0);

    // Back-to-back with arready held high
    push_a(mk(1'b0, 32'h2000, 4'd1, 8'd0, 3'd3, BURST_INCR), 1'b1);
    push_a(mk(1'b0, 32'h2040, 4'd2, 8'd3, 3'd2, BURST_WRAP), 1'b1);
    push_a(mk(1'b0, 32'h3000, 4'd15, 8'd255, 3'd0, BURST_FIXED), 1'b1);
    tick();
    chk("t2_arvalid", 64'(arvalid_a), 64'd1);
    tick();
    tick();
    tick();
    chk("t2_hs_count", 64'(hn_a), 64'd4);
    chk("t2_no_bubble", 64'(hc_a[3] - hc_a[1]), 64'd2);
    chk("t2_outst", 64'(outst_a), 64'd3);
    chk("t2_arvalid_idle", 64'(arvalid_a), 64'd0);
    score_a();
    rvalid_a = 1'b1; rlast_a = 1'b1;
    tick();
    tick();
    tick();
    rvalid_a = 1'b0; rlast_a = 1'b0;
    chk("t2_drained", 64'(outst_a), 64'd0);

    // AR backpressure: held stable for 5 cycles, next entry waits
    arready_a = 1'b0;
    push_a(mk(1'b0, 32'h4000, 4'd5, 8'd1, 3'd2, BURST_INCR), 1'b1);
    push_a(mk(1'b0, 32'h5000, 4'd6, 8'd2, 3'd2, BURST_INCR), 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t4_arvalid_hold", 64'(arvalid_a), 64'd1);
      chk("t4_payload_hold", 64'({araddr_a, arid_a, arlen_a}), 64'({32'h4000, 4'd5, 8'd1}));
      chk("t4_no_pop", 64'(pr_a), 64'd0);
      if (i == 4) arready_a = 1'b1;
      tick();
    end
    chk("t4_hs_count", 64'(hn_a), 64'd5);
    chk("t4_next_addr", 64'(araddr_a), 64'h5000);
    chk("t4_next_arvalid", 64'(arvalid_a), 64'd1);
    chk("t4_outst1", 64'(outst_a), 64'd1);
    tick();
    chk("t4_outst2", 64'(outst_a), 64'd2);
    chk("t4_idle", 64'(arvalid_a), 64'd0);
    score_a();

    // Simultaneous ar_hs and r_done at outstanding=2, then underflow
    push_a(mk(1'b0, 32'h6000, 4'd7, 8'd0, 3'd1, BURST_INCR), 1'b1);
    tick();
    chk("t5_arvalid", 64'(arvalid_a), 64'd1);
    chk("t5_outst_pre", 64'(outst_a), 64'd2);
    rvalid_a = 1'b1; rlast_a = 1'b1;
    tick();
    chk("t5_outst_same", 64'(outst_a), 64'd2);
    chk("t5_hs_count", 64'(hn_a), 64'd7);
    tick();
    tick();
    chk("t5_outst_zero", 64'(outst_a), 64'd0);
    chk("t5_no_underflow_yet", 64'(eund_a), 64'd0);
    tick();
    rvalid_a = 1'b0; rlast_a = 1'b0;
    chk("t5_underflow", 64'(eund_a), 64'd1);
    chk("t5_outst_stays0", 64'(outst_a), 64'd0);
    chk("t5_busy", 64'(busy_a), 64'd0);
    score_a();

    // Write entry in the read FIFO
    push_a(mk(1'b1, 32'h7000, 4'd4, 8'd0, 3'd2, BURST_INCR), 1'b0);
    tick();
    chk("t6_popped", 64'(pv_a), 64'd0);
    chk("t6_err_bad", 64'(ebad_a), 64'd1);
    chk("t6_no_ar", 64'(arvalid_a), 64'd0);
    tick();
    chk("t6_no_hs", 64'(hn_a), 64'd7);

    // Reset while an entry is held in ISSUE with one read in flight
    push_a(mk(1'b0, 32'h8000, 4'd8, 8'd0, 3'd2, BURST_INCR), 1'b1);
    push_a(mk(1'b0, 32'h9000, 4'd9, 8'd0, 3'd2, BURST_INCR), 1'b0);
    tick();
    tick();
    arready_a = 1'b0;
    tick();
    chk("t7_issue", 64'(arvalid_a), 64'd1);
    chk("t7_addr", 64'(araddr_a), 64'h9000);
    chk("t7_outst", 64'(outst_a), 64'd1);
    score_a();
    aresetn = 1'b0;
    tick();
    chk("t7_rst_arvalid", 64'(arvalid_a), 64'd0);
    chk("t7_rst_outst", 64'(outst_a), 64'd0);
    chk("t7_rst_err_bad", 64'(ebad_a), 64'd0);
    chk("t7_rst_err_underflow", 64'(eund_a), 64'd0);
    chk("t7_rst_busy", 64'(busy_a), 64'd0);
    chk("t7_rst_addr", 64'(araddr_a), 64'd0);
    aresetn = 1'b1;
    tick();

    // Credit stall on the 2-credit instance
    arready_b = 1'b1;
    push_b(mk(1'b0, 32'hA000, 4'd0, 8'd0, 3'd2, BURST_INCR), 1'b1);
    push_b(mk(1'b0, 32'hA100, 4'd1, 8'd1, 3'd2, BURST_INCR), 1'b1);
    push_b(mk(1'b0, 32'hA200, 4'd2, 8'd2, 3'd2, BURST_INCR), 1'b1);
    push_b(mk(1'b0, 32'hA300, 4'd3, 8'd3, 3'd2, BURST_INCR), 1'b1);
    tick();
    tick();
    tick();
    chk("t3_hs_count", 64'(hn_b), 64'd2);
    chk("t3_outst_full", 64'(outst_b), 64'd2);
    chk("t3_stall_ready", 64'(pr_b), 64'd0);
    chk("t3_stall_arvalid", 64'(arvalid_b), 64'd0);
    tick();
    tick();
    chk("t3_still_stalled", 64'(pr_b), 64'd0);
    chk("t3_hs_still2", 64'(hn_b), 64'd2);
    rdc = cyc;
    rvalid_b = 1'b1; rlast_b = 1'b1;
    tick();
    rvalid_b = 1'b0; rlast_b = 1'b0;
    chk("t3_outst_freed", 64'(outst_b), 64'd1);
    chk("t3_ready_after_credit", 64'(pr_b), 64'd1);
    tick();
    chk("t3_arvalid3", 64'(arvalid_b), 64'd1);
    tick();
    chk("t3_hs_count3", 64'(hn_b), 64'd3);
    chk("t3_hs_latency", 64'(hc_b[2] - rdc), 64'd2);
    chk("t3_outst_full2", 64'(outst_b), 64'd2);
    chk("t3_stall_again", 64'(pr_b), 64'd0);
    score_b();
    chk("t3_one_left", 64'(exp_b.size()), 64'd1);

    score_a();
    chk("a_all_issued", 64'(exp_a.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
